// File: rtl/rf_pkg.sv
// Shared definitions for the RISC16 multiport register file: default geometry,
// the hardwired-zero register index and the address-match helper used by both
// the bypass muxes and the scoreboard clear/set logic.
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;
    localparam int R0_IDX    = 0;

    // True when an enabled write (or reserve) targets the given read/flop index.
    // Addresses are widened to 32 bits by the caller so one helper serves any ADDR_W.
    function automatic logic hit(input logic we, input logic [31:0] waddr, input logic [31:0] raddr);
        return we && (waddr == raddr);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: a reserve marks a register as awaiting a result,
// a writeback on either port clears it. A reserve landing on the same edge as a
// write to the same register wins, because it names a newer producer.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_a_en_i,
    input  logic [ADDR_W-1:0] clr_a_addr_i,
    input  logic              clr_b_en_i,
    input  logic [ADDR_W-1:0] clr_b_addr_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic [ADDR_W-1:0] tap_a_addr_i,
    input  logic [ADDR_W-1:0] tap_b_addr_i,
    output logic              tap_a_o,
    output logic              tap_b_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy vector: clears first, then the reserve overrides (r0 never reserved).
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit(clr_a_en_i, 32'(clr_a_addr_i), i)) busy_d[i] = 1'b0;
            if (hit(clr_b_en_i, 32'(clr_b_addr_i), i)) busy_d[i] = 1'b0;
            if (hit(set_en_i, 32'(set_addr_i), i) && !((ZERO_REG != 0) && (i == R0_IDX)))
                busy_d[i] = 1'b1;
        end
    end

    // Busy flops, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign tap_a_o = busy_q[tap_a_addr_i];
    assign tap_b_o = busy_q[tap_b_addr_i];

endmodule

// File: rtl/rf_multiport_sb.sv
// Two-read / two-write register file for the RISC16 datapath with optional
// hardwired-zero r0, optional write-to-read forwarding, write-port collision
// flag and a busy scoreboard. Port A is the priority writer on collisions.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              ra_busy,
    output logic              rb_busy,
    output logic              wr_collide
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              collide_q;
    logic              collide_d;
    logic              tapA;
    logic              tapB;
    logic              hitAA, hitBA, hitAB, hitBB;
    logic              weALive, weBLive;

    // Forwarding is suppressed while reset is held so reads show the cleared file.
    assign weALive = we_a & rst_n;
    assign weBLive = we_b & rst_n;

    // Next storage contents: port B first so port A overwrites it on a collision.
    always_comb begin
        mem_d = mem_q;
        if (we_b) mem_d[wb_addr] = wb_data;
        if (we_a) mem_d[wa_addr] = wa_data;
        if (ZERO_REG != 0) mem_d[R0_IDX] = '0;
    end

    // Storage array, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign collide_d = we_a && we_b && (wa_addr == wb_addr);

    // Collision flag holds for the one cycle after the offending edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) collide_q <= 1'b0;
        else        collide_q <= collide_d;
    end

    assign wr_collide = collide_q;

    // Address matches between live writes and each read port.
    always_comb begin
        hitAA = hit(weALive, 32'(wa_addr), 32'(ra_addr));
        hitBA = hit(weBLive, 32'(wb_addr), 32'(ra_addr));
        hitAB = hit(weALive, 32'(wa_addr), 32'(rb_addr));
        hitBB = hit(weBLive, 32'(wb_addr), 32'(rb_addr));
    end

    // Read port A: zero register, then forwarded data (A before B), then storage.
    always_comb begin
        ra_data = mem_q[ra_addr];
        if ((ZERO_REG != 0) && (ra_addr == ADDR_W'(R0_IDX))) ra_data = '0;
        else if ((BYPASS != 0) && hitAA)                     ra_data = wa_data;
        else if ((BYPASS != 0) && hitBA)                     ra_data = wb_data;
    end

    // Read port B: same priority as port A.
    always_comb begin
        rb_data = mem_q[rb_addr];
        if ((ZERO_REG != 0) && (rb_addr == ADDR_W'(R0_IDX))) rb_data = '0;
        else if ((BYPASS != 0) && hitAB)                     rb_data = wa_data;
        else if ((BYPASS != 0) && hitBB)                     rb_data = wb_data;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_a_en_i   (we_a),
        .clr_a_addr_i (wa_addr),
        .clr_b_en_i   (we_b),
        .clr_b_addr_i (wb_addr),
        .set_en_i     (rsv_en),
        .set_addr_i   (rsv_addr),
        .tap_a_addr_i (ra_addr),
        .tap_b_addr_i (rb_addr),
        .tap_a_o      (tapA),
        .tap_b_o      (tapB)
    );

    // A register whose result is being forwarded this cycle is not reported busy.
    always_comb begin
        ra_busy = tapA && !((BYPASS != 0) && (hitAA || hitBA));
        rb_busy = tapB && !((BYPASS != 0) && (hitAB || hitBB));
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench for rf_multiport_sb. Two builds share one stimulus stream:
// dut1 (BYPASS=1, ZERO_REG=1) and dut0 (BYPASS=0, ZERO_REG=0). A register-file
// model tracks both and is compared every negedge; directed literals pin key cases.
module tb_rf_multiport_sb;

    logic        clk;
    logic        rst_n;
    logic        weA, weB, rsvEn;
    logic [2:0]  waAddr, wbAddr, raAddr, rbAddr, rsvAddr;
    logic [15:0] waData, wbData;

    logic [15:0] raData1, rbData1, raData0, rbData0;
    logic        raBusy1, rbBusy1, coll1, raBusy0, rbBusy0, coll0;

    int compareCount  = 0;
    int mismatchCount = 0;
    logic monOn = 1'b0;

    // Model state, index 0 = dut0 build, 1 = dut1 build.
    logic [15:0] modelMem  [2][8];
    logic        modelBusy [2][8];
    logic        modelColl [2];

    rf_multiport_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .we_a(weA), .wa_addr(waAddr), .wa_data(waData),
        .we_b(weB), .wb_addr(wbAddr), .wb_data(wbData),
        .ra_addr(raAddr), .ra_data(raData1),
        .rb_addr(rbAddr), .rb_data(rbData1),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr),
        .ra_busy(raBusy1), .rb_busy(rbBusy1), .wr_collide(coll1)
    );

    rf_multiport_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .we_a(weA), .wa_addr(waAddr), .wa_data(waData),
        .we_b(weB), .wb_addr(wbAddr), .wb_data(wbData),
        .ra_addr(raAddr), .ra_data(raData0),
        .rb_addr(rbAddr), .rb_data(rbData0),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr),
        .ra_busy(raBusy0), .rb_busy(rbBusy0), .wr_collide(coll0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build flags of each modelled configuration.
    function automatic bit cfgZero(int c);
        return (c == 1);
    endfunction

    function automatic bit cfgBypass(int c);
        return (c == 1);
    endfunction

    // Register file semantics applied at each clock edge; reset clears everything at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                modelColl[c] = 1'b0;
                for (int r = 0; r < 8; r++) begin
                    modelMem[c][r]  = 16'h0000;
                    modelBusy[c][r] = 1'b0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (weB && !(weA && waAddr == wbAddr)) modelMem[c][wbAddr] = wbData;
                if (weA) modelMem[c][waAddr] = waData;
                if (cfgZero(c)) modelMem[c][0] = 16'h0000;
                if (weA) modelBusy[c][waAddr] = 1'b0;
                if (weB) modelBusy[c][wbAddr] = 1'b0;
                if (rsvEn && !(cfgZero(c) && rsvAddr == 3'd0)) modelBusy[c][rsvAddr] = 1'b1;
                modelColl[c] = weA && weB && (waAddr == wbAddr);
            end
        end
    end

    // What a read of addr must return in configuration c right now.
    function automatic logic [15:0] expData(int c, logic [2:0] addr);
        if (!rst_n) return 16'h0000;
        if (cfgZero(c) && addr == 3'd0) return 16'h0000;
        if (cfgBypass(c) && weA && waAddr == addr) return waData;
        if (cfgBypass(c) && weB && wbAddr == addr) return wbData;
        return modelMem[c][addr];
    endfunction

    function automatic logic expBusy(int c, logic [2:0] addr);
        if (!rst_n) return 1'b0;
        if (cfgBypass(c) && ((weA && waAddr == addr) || (weB && wbAddr == addr))) return 1'b0;
        return modelBusy[c][addr];
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both builds against the model.
    always @(negedge clk) begin
        if (monOn) begin
            checkOutput("mon.d1.ra_data", raData1, expData(1, raAddr));
            checkOutput("mon.d1.rb_data", rbData1, expData(1, rbAddr));
            checkOutput("mon.d1.ra_busy", 16'(raBusy1), 16'(expBusy(1, raAddr)));
            checkOutput("mon.d1.rb_busy", 16'(rbBusy1), 16'(expBusy(1, rbAddr)));
            checkOutput("mon.d1.collide", 16'(coll1), 16'(modelColl[1]));
            checkOutput("mon.d0.ra_data", raData0, expData(0, raAddr));
            checkOutput("mon.d0.rb_data", rbData0, expData(0, rbAddr));
            checkOutput("mon.d0.ra_busy", 16'(raBusy0), 16'(expBusy(0, raAddr)));
            checkOutput("mon.d0.rb_busy", 16'(rbBusy0), 16'(expBusy(0, rbAddr)));
            checkOutput("mon.d0.collide", 16'(coll0), 16'(modelColl[0]));
        end
    end

    task automatic applyStimulus(input logic wea, input logic [2:0] waa, input logic [15:0] wad,
                                 input logic web, input logic [2:0] wba, input logic [15:0] wbd,
                                 input logic [2:0] ra, input logic [2:0] rb,
                                 input logic rsv, input logic [2:0] rsva);
        weA = wea; waAddr = waa; waData = wad;
        weB = web; wbAddr = wba; wbData = wbd;
        raAddr = ra; rbAddr = rb;
        rsvEn = rsv; rsvAddr = rsva;
    endtask

    task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
        applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, ra, rb, 0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle(3'd1, 3'd2);
        monOn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst.ra_data", raData1, 16'h0000);
        checkOutput("rst.ra_busy", 16'(raBusy1), 16'h0);
        tick();
        rst_n = 1'b1;

        // Every address reads zero and idle after reset.
        for (int a = 0; a < 8; a++) begin
            idle(3'(a), 3'(7 - a));
            @(negedge clk);
            checkOutput("t1.ra_data", raData1, 16'h0000);
            checkOutput("t1.rb_data0", rbData0, 16'h0000);
            checkOutput("t1.rb_busy", 16'(rbBusy1), 16'h0);
            tick();
        end

        // Reset asserted mid-cycle while a write is pending.
        applyStimulus(1, 3'd4, 16'h7777, 0, 3'd0, 16'h0, 3'd4, 3'd4, 0, 3'd0);
        tick();
        idle(3'd4, 3'd4);
        @(negedge clk);
        checkOutput("t1.r4_before", raData0, 16'h7777);
        tick();
        applyStimulus(1, 3'd4, 16'h8888, 0, 3'd0, 16'h0, 3'd4, 3'd4, 0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t1.mid_rst.d1", raData1, 16'h0000);
        checkOutput("t1.mid_rst.d0", raData0, 16'h0000);
        tick();
        idle(3'd4, 3'd4);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t1.r4_after", raData0, 16'h0000);
        tick();

        // Back-to-back writes to r6; r3 untouched.
        applyStimulus(1, 3'd6, 16'hABCD, 0, 3'd0, 16'h0, 3'd6, 3'd3, 0, 3'd0);
        tick();
        applyStimulus(1, 3'd6, 16'h1234, 0, 3'd0, 16'h0, 3'd6, 3'd3, 0, 3'd0);
        tick();
        idle(3'd6, 3'd3);
        @(negedge clk);
        checkOutput("t2.ra_r6", raData1, 16'h1234);
        checkOutput("t2.ra_r6.d0", raData0, 16'h1234);
        checkOutput("t2.rb_r3", rbData1, 16'h0000);
        tick();

        // Forwarding versus next-cycle visibility.
        applyStimulus(1, 3'd3, 16'h5A5A, 0, 3'd0, 16'h0, 3'd3, 3'd3, 0, 3'd0);
        @(negedge clk);
        checkOutput("t3.bypass", raData1, 16'h5A5A);
        checkOutput("t3.nobypass", raData0, 16'h0000);
        tick();
        idle(3'd3, 3'd3);
        @(negedge clk);
        checkOutput("t3.nobypass_next", raData0, 16'h5A5A);
        tick();

        // Write-port collision: port A wins, flag for one cycle.
        applyStimulus(1, 3'd2, 16'h1111, 1, 3'd2, 16'h2222, 3'd2, 3'd2, 0, 3'd0);
        @(negedge clk);
        checkOutput("t4.bypass_prio", raData1, 16'h1111);
        tick();
        idle(3'd2, 3'd2);
        @(negedge clk);
        checkOutput("t4.collide", 16'(coll1), 16'h1);
        checkOutput("t4.collide.d0", 16'(coll0), 16'h1);
        checkOutput("t4.r2", raData0, 16'h1111);
        tick();
        @(negedge clk);
        checkOutput("t4.collide_drop", 16'(coll1), 16'h0);
        tick();

        // Scoreboard reserve / clear / same-edge priority.
        applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd5, 3'd5, 1, 3'd5);
        tick();
        idle(3'd5, 3'd5);
        @(negedge clk);
        checkOutput("t5.busy", 16'(raBusy1), 16'h1);
        checkOutput("t5.busy.d0", 16'(raBusy0), 16'h1);
        tick();
        applyStimulus(0, 3'd0, 16'h0, 1, 3'd5, 16'h00FF, 3'd5, 3'd5, 0, 3'd0);
        @(negedge clk);
        checkOutput("t5.busy_fwd", 16'(raBusy1), 16'h0);
        checkOutput("t5.busy_raw.d0", 16'(raBusy0), 16'h1);
        tick();
        idle(3'd5, 3'd5);
        @(negedge clk);
        checkOutput("t5.cleared", 16'(raBusy0), 16'h0);
        checkOutput("t5.data", raData0, 16'h00FF);
        tick();
        applyStimulus(1, 3'd5, 16'hBEEF, 0, 3'd0, 16'h0, 3'd5, 3'd5, 1, 3'd5);
        tick();
        idle(3'd5, 3'd5);
        @(negedge clk);
        checkOutput("t5.set_wins", 16'(raBusy1), 16'h1);
        checkOutput("t5.set_wins.d0", 16'(rbBusy0), 16'h1);
        checkOutput("t5.new_data", raData1, 16'hBEEF);
        tick();
        applyStimulus(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 3'd5, 3'd5, 1, 3'd5);
        tick();
        idle(3'd5, 3'd5);
        @(negedge clk);
        checkOutput("t5.rsv_again", 16'(raBusy1), 16'h1);
        tick();

        // Hardwired zero register on dut1, ordinary register on dut0.
        applyStimulus(1, 3'd0, 16'hFFFF, 0, 3'd0, 16'h0, 3'd0, 3'd0, 1, 3'd0);
        @(negedge clk);
        checkOutput("t6.r0_fwd", raData1, 16'h0000);
        checkOutput("t6.r0_busy_fwd", 16'(rbBusy1), 16'h0);
        tick();
        idle(3'd0, 3'd0);
        @(negedge clk);
        checkOutput("t6.r0", raData1, 16'h0000);
        checkOutput("t6.r0_busy", 16'(raBusy1), 16'h0);
        checkOutput("t6.r0.d0", raData0, 16'hFFFF);
        checkOutput("t6.r0_busy.d0", 16'(raBusy0), 16'h1);
        tick();
        applyStimulus(1, 3'd0, 16'h0001, 1, 3'd0, 16'h0002, 3'd0, 3'd1, 0, 3'd0);
        tick();
        idle(3'd0, 3'd1);
        @(negedge clk);
        checkOutput("t6.r0_collide", 16'(coll1), 16'h1);
        tick();

        // Mixed traffic checked only by the model.
        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom), 3'($urandom), 16'($urandom),
                          1'($urandom), 3'($urandom), 16'($urandom),
                          3'($urandom), 3'($urandom),
                          1'($urandom), 3'($urandom));
            tick();
        end
        idle(3'd0, 3'd0);
        tick();

        monOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
